// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back arbiter and its producers / the register file.
// The forwarding signals exist only when WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_alu_valid;
  logic [4:0]        i_alu_rd;
  logic [DATA_W-1:0] i_alu_data;
  logic              i_lu_valid;
  logic              o_lu_ready;
  logic [4:0]        i_lu_rd;
  logic [DATA_W-1:0] i_lu_data;
  logic [4:0]        o_write_reg;
  logic [DATA_W-1:0] o_writedata;
  logic              o_writedatasignal;
  logic [31:0]       o_pend_mask;
  logic [CNT_W-1:0]  o_fifo_count;
`ifdef WB_FWD_EN
  logic [4:0]        i_fwd_reg;
  logic              o_fwd_hit;
  logic [DATA_W-1:0] o_fwd_data;

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data, i_lu_valid, i_lu_rd, i_lu_data, i_fwd_reg,
    input  o_lu_ready, o_write_reg, o_writedata, o_writedatasignal, o_pend_mask,
           o_fifo_count, o_fwd_hit, o_fwd_data
  );
  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data, i_lu_valid, i_lu_rd, i_lu_data, i_fwd_reg,
    output o_lu_ready, o_write_reg, o_writedata, o_writedatasignal, o_pend_mask,
           o_fifo_count, o_fwd_hit, o_fwd_data
  );
`else
  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data, i_lu_valid, i_lu_rd, i_lu_data,
    input  o_lu_ready, o_write_reg, o_writedata, o_writedatasignal, o_pend_mask,
           o_fifo_count
  );
  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data, i_lu_valid, i_lu_rd, i_lu_data,
    output o_lu_ready, o_write_reg, o_writedata, o_writedatasignal, o_pend_mask,
           o_fifo_count
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register-file write port: ALU results win, long-latency results queue in a FIFO.
// Optional write-port forwarding compare is enabled with WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [4:0]        rd_mem_q   [DEPTH];
  logic [4:0]        rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [4:0]        write_reg_q, write_reg_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              wsig_q, wsig_d;
  logic              lu_ready, push, pop;
  logic [31:0]       pend_mask;
  logic [PTR_W-1:0]  offset;

  always_comb begin
    lu_ready = count_q < CNT_W'(DEPTH);
    // rd==0 transfers are handshaked but never stored
    push = bus.i_lu_valid && lu_ready && (bus.i_lu_rd != 5'd0);
    pop  = !bus.i_alu_valid && (count_q != '0);

    rd_mem_d    = rd_mem_q;
    data_mem_d  = data_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    write_reg_d = write_reg_q;
    writedata_d = writedata_q;
    wsig_d      = 1'b0;

    if (push) begin
      rd_mem_d[wr_ptr_q]   = bus.i_lu_rd;
      data_mem_d[wr_ptr_q] = bus.i_lu_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (bus.i_alu_valid) begin
      write_reg_d = bus.i_alu_rd;
      writedata_d = bus.i_alu_data;
      wsig_d      = (bus.i_alu_rd != 5'd0);
    end else if (pop) begin
      write_reg_d = rd_mem_q[rd_ptr_q];
      writedata_d = data_mem_q[rd_ptr_q];
      wsig_d      = 1'b1;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    pend_mask = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        pend_mask[rd_mem_q[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      write_reg_q <= '0;
      writedata_q <= '0;
      wsig_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      write_reg_q <= write_reg_d;
      writedata_q <= writedata_d;
      wsig_q      <= wsig_d;
      rd_mem_q    <= rd_mem_d;
      data_mem_q  <= data_mem_d;
    end
  end

  assign bus.o_lu_ready        = lu_ready;
  assign bus.o_write_reg       = write_reg_q;
  assign bus.o_writedata       = writedata_q;
  assign bus.o_writedatasignal = wsig_q;
  assign bus.o_pend_mask       = pend_mask;
  assign bus.o_fifo_count      = count_q;

`ifdef WB_FWD_EN
  assign bus.o_fwd_hit  = wsig_q && (write_reg_q == bus.i_fwd_reg) && (bus.i_fwd_reg != 5'd0);
  assign bus.o_fwd_data = writedata_q;
`endif

endmodule
